// File: rtl/id_stage_if.sv
// Bundle of IF/ID inputs, regfile read port, hazard output and ID/EX register outputs.
// The id_stage sits on the slave modport; the surrounding pipeline drives the master side.
interface id_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic            if_valid;
  logic [31:0]     if_insn;
  logic [XLEN-1:0] if_pc;
  logic            stall_i;
  logic            flush_i;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            id_stall_o;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_rs1_addr;
  logic [AW-1:0]   ex_rs2_addr;
  logic [AW-1:0]   ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_illegal;

  modport master (
    output if_valid, if_insn, if_pc, stall_i, flush_i, rs1_data, rs2_data,
    input  rs1_addr, rs2_addr, id_stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
  );

  modport slave (
    input  if_valid, if_insn, if_pc, stall_i, flush_i, rs1_data, rs2_data,
    output rs1_addr, rs2_addr, id_stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: field split, immediate/control decode, load-use detection, ID/EX register.
// Optional macro ID_ILLEGAL_CHECK_EN flags unknown opcodes through ex_illegal.
module id_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_stage_if.slave    bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  logic [31:0]   insn;
  logic [6:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;

  assign insn   = bus.if_insn;
  assign opcode = insn[6:0];
  assign rs1    = insn[15 +: AW];
  assign rs2    = insn[20 +: AW];
  assign rd     = insn[7 +: AW];

  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2;

  logic [31:0] imm32;
  logic        dec_rw, dec_mr, dec_mw, use_rs1, use_rs2, known;
  logic        ctl_rw, ctl_mr, ctl_mw, ctl_ill;

  always_comb begin
    imm32   = '0;
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    known   = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm32   = {insn[31:12], 12'b0};
        dec_rw  = 1'b1;
        use_rs1 = 1'b0;
      end
      OPC_JAL: begin
        imm32   = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
        dec_rw  = 1'b1;
        use_rs1 = 1'b0;
      end
      OPC_JALR, OPC_OPIMM: begin
        imm32  = {{20{insn[31]}}, insn[31:20]};
        dec_rw = 1'b1;
      end
      OPC_LOAD: begin
        imm32  = {{20{insn[31]}}, insn[31:20]};
        dec_rw = 1'b1;
        dec_mr = 1'b1;
      end
      OPC_STORE: begin
        imm32   = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        dec_mw  = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm32   = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        use_rs2 = 1'b1;
      end
      OPC_OP: begin
        dec_rw  = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_MISCMEM, OPC_SYSTEM: ;
      default: known = 1'b0;
    endcase
  end

  // Unknown opcodes never write or touch memory, whether or not they are flagged.
  assign ctl_rw = dec_rw & known & (rd != '0);
  assign ctl_mr = dec_mr & known;
  assign ctl_mw = dec_mw & known;
`ifdef ID_ILLEGAL_CHECK_EN
  assign ctl_ill = ~known;
`else
  assign ctl_ill = 1'b0;
`endif

  logic            ex_valid, ex_rw, ex_mr, ex_mw, ex_ill, ex_f7b5;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0]   ex_rs1_addr, ex_rs2_addr, ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            load_use;

  assign load_use = bus.if_valid & ex_valid & ex_mr & (ex_rd != '0) &
                    ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  assign bus.id_stall_o = rst_n & (load_use | bus.stall_i) & ~bus.flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_mw       <= 1'b0;
      ex_ill      <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_f7b5     <= 1'b0;
    end else begin
      if (bus.flush_i || (!bus.stall_i && load_use)) begin
        ex_valid <= 1'b0;
        ex_rw    <= 1'b0;
        ex_mr    <= 1'b0;
        ex_mw    <= 1'b0;
        ex_ill   <= 1'b0;
      end else if (!bus.stall_i) begin
        ex_valid <= bus.if_valid;
        ex_rw    <= bus.if_valid & ctl_rw;
        ex_mr    <= bus.if_valid & ctl_mr;
        ex_mw    <= bus.if_valid & ctl_mw;
        ex_ill   <= bus.if_valid & ctl_ill;
      end
      // Datapath fields are don't-care on a bubble, so only stall/flush gate them.
      if (!bus.stall_i && !bus.flush_i) begin
        ex_pc       <= bus.if_pc;
        ex_rs1_data <= bus.rs1_data;
        ex_rs2_data <= bus.rs2_data;
        ex_imm      <= {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        ex_rs1_addr <= rs1;
        ex_rs2_addr <= rs2;
        ex_rd       <= rd;
        ex_opcode   <= opcode;
        ex_funct3   <= insn[14:12];
        ex_f7b5     <= insn[30];
      end
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_pc        = ex_pc;
  assign bus.ex_rs1_data  = ex_rs1_data;
  assign bus.ex_rs2_data  = ex_rs2_data;
  assign bus.ex_imm       = ex_imm;
  assign bus.ex_rs1_addr  = ex_rs1_addr;
  assign bus.ex_rs2_addr  = ex_rs2_addr;
  assign bus.ex_rd        = ex_rd;
  assign bus.ex_opcode    = ex_opcode;
  assign bus.ex_funct3    = ex_funct3;
  assign bus.ex_funct7b5  = ex_f7b5;
  assign bus.ex_reg_write = ex_rw;
  assign bus.ex_mem_read  = ex_mr;
  assign bus.ex_mem_write = ex_mw;
  assign bus.ex_illegal   = ex_ill;
endmodule
